// File: rtl/cva6_ras_pkg.sv
// Shared types and helpers for the CVA6 return-address stack
// with per-branch checkpointing.
package cva6_ras_pkg;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_PUSH_POP
  } ras_op_e;

  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cva6_ras_ckpt_file.sv
// Checkpoint register file: one save port, one restore port,
// valid bit per slot, bulk invalidate on flush.
module cva6_ras_ckpt_file #(
  parameter int unsigned NR   = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned ID_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            we_i,
  input  logic [ID_W-1:0] waddr_i,
  input  logic [W-1:0]    wdata_i,
  input  logic [ID_W-1:0] raddr_i,
  output logic [W-1:0]    rdata_o,
  output logic            rvalid_o
);

  logic [W-1:0]  data_q [NR];
  logic [W-1:0]  data_d [NR];
  logic [NR-1:0] valid_q;
  logic [NR-1:0] valid_d;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok = 32'(waddr_i) < NR;
  assign rd_ok = 32'(raddr_i) < NR;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (we_i && wr_ok) begin
      data_d[waddr_i]  = wdata_i;
      valid_d[waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  // Reads see pre-edge contents, so a same-slot save+restore
  // restores the old snapshot.
  assign rvalid_o = rd_ok && valid_q[raddr_i];
  assign rdata_o  = data_q[raddr_i];

endmodule

// File: rtl/cva6_ras_ckpt.sv
// Circular return-address stack with overwrite-oldest overflow,
// combined pop+push, and checkpoint/restore for mispredicts.
module cva6_ras_ckpt
  import cva6_ras_pkg::*;
#(
  parameter int unsigned VLEN    = 64,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NR_CKPT = 4,
  localparam int unsigned PTR_W  = ras_ptr_w(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned ID_W   =
    (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VLEN-1:0]  data_i,
  output logic [VLEN-1:0]  data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             overflow_o,
  input  logic             ckpt_save_i,
  input  logic [ID_W-1:0]  ckpt_id_i,
  input  logic             restore_i,
  input  logic [ID_W-1:0]  restore_id_i
);

  typedef struct packed {
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] cnt;
    logic [VLEN-1:0]  top;
  } ckpt_t;

  localparam int unsigned CK_W = $bits(ckpt_t);

  logic [VLEN-1:0]  mem_q [DEPTH];
  logic [VLEN-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] tos_inc;
  logic             full;
  logic             empty;
  ras_op_e          op;
  ckpt_t            save_data;
  ckpt_t            rd_data;
  logic [CK_W-1:0]  rd_raw;
  logic             rd_valid;

  assign tos_inc = tos_q + PTR_W'(1);
  assign full    = cnt_q == CNT_W'(DEPTH);
  assign empty   = cnt_q == '0;

  always_comb begin
    op = RAS_NONE;
    unique case ({push_i, pop_i})
      2'b10:   op = RAS_PUSH;
      2'b01:   op = RAS_POP;
      2'b11:   op = RAS_PUSH_POP;
      default: op = RAS_NONE;
    endcase
  end

  // Snapshot is always the pre-update state of this cycle.
  assign save_data.tos = tos_q;
  assign save_data.cnt = cnt_q;
  assign save_data.top = mem_q[tos_q];
  assign rd_data       = rd_raw;

  cva6_ras_ckpt_file #(
    .NR   (NR_CKPT),
    .W    (CK_W),
    .ID_W (ID_W)
  ) i_ckpt_file (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .we_i     (ckpt_save_i),
    .waddr_i  (ckpt_id_i),
    .wdata_i  (save_data),
    .raddr_i  (restore_id_i),
    .rdata_o  (rd_raw),
    .rvalid_o (rd_valid)
  );

  always_comb begin
    mem_d = mem_q;
    tos_d = tos_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (flush_i) begin
      tos_d = '0;
      cnt_d = '0;
    end else if (restore_i) begin
      if (rd_valid) begin
        tos_d = rd_data.tos;
        cnt_d = rd_data.cnt;
        if (rd_data.cnt != '0) begin
          mem_d[rd_data.tos] = rd_data.top;
        end
      end
    end else begin
      unique case (op)
        RAS_PUSH_POP: begin
          if (!empty) begin
            mem_d[tos_q] = data_i;
          end else begin
            tos_d          = tos_inc;
            mem_d[tos_inc] = data_i;
            cnt_d          = cnt_q + CNT_W'(1);
          end
        end
        RAS_PUSH: begin
          tos_d          = tos_inc;
          mem_d[tos_inc] = data_i;
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RAS_POP: begin
          if (!empty) begin
            tos_d = tos_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign valid_o     = !empty;
  assign data_o      = empty ? '0 : mem_q[tos_q];
  assign occupancy_o = cnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cva6_ras_ckpt.sv
// Self-checking bench for cva6_ras_ckpt: directed scenarios plus
// randomized traffic against a behavioural stack model.
module tb_cva6_ras_ckpt;

  localparam int VLEN  = 64;
  localparam int DEPTH = 4;
  localparam int NCK   = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            push_i = 1'b0;
  logic            pop_i = 1'b0;
  logic [VLEN-1:0] data_i = '0;
  logic [VLEN-1:0] data_o;
  logic            valid_o;
  logic [2:0]      occupancy_o;
  logic            overflow_o;
  logic            ckpt_save_i = 1'b0;
  logic [1:0]      ckpt_id_i = '0;
  logic            restore_i = 1'b0;
  logic [1:0]      restore_id_i = '0;

  int n_run = 0;
  int n_fail = 0;

  // Model state: circular array with explicit pointer and count
  logic [VLEN-1:0] m_mem [DEPTH];
  int              m_tos;
  int              m_cnt;
  bit              m_ovf;
  bit              ck_v   [NCK];
  int              ck_tos [NCK];
  int              ck_cnt [NCK];
  logic [VLEN-1:0] ck_top [NCK];

  always #5 clk = ~clk;

  cva6_ras_ckpt #(
    .VLEN    (VLEN),
    .DEPTH   (DEPTH),
    .NR_CKPT (NCK)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_i       (push_i),
    .pop_i        (pop_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .occupancy_o  (occupancy_o),
    .overflow_o   (overflow_o),
    .ckpt_save_i  (ckpt_save_i),
    .ckpt_id_i    (ckpt_id_i),
    .restore_i    (restore_i),
    .restore_id_i (restore_id_i)
  );

  task automatic model_step(
    input bit rs, input bit fl, input bit pu, input bit po,
    input logic [VLEN-1:0] d, input bit sv, input int sid,
    input bit rr, input int rid);
    int              s_tos;
    int              s_cnt;
    logic [VLEN-1:0] s_top;
    s_tos = m_tos;
    s_cnt = m_cnt;
    s_top = m_mem[m_tos];
    m_ovf = 0;
    if (rs || fl) begin
      m_tos = 0;
      m_cnt = 0;
      for (int i = 0; i < NCK; i++) ck_v[i] = 0;
      return;
    end
    if (rr) begin
      if (ck_v[rid]) begin
        m_tos = ck_tos[rid];
        m_cnt = ck_cnt[rid];
        if (m_cnt > 0) m_mem[m_tos] = ck_top[rid];
      end
    end else if (pu && po && m_cnt > 0) begin
      m_mem[m_tos] = d;
    end else if (pu) begin
      m_tos = (m_tos + 1) % DEPTH;
      m_mem[m_tos] = d;
      if (m_cnt == DEPTH) m_ovf = 1;
      else m_cnt++;
    end else if (po && m_cnt > 0) begin
      m_tos = (m_tos + DEPTH - 1) % DEPTH;
      m_cnt--;
    end
    if (sv) begin
      ck_v[sid]   = 1;
      ck_tos[sid] = s_tos;
      ck_cnt[sid] = s_cnt;
      ck_top[sid] = s_top;
    end
  endtask

  task automatic step(
    input bit rs, input bit fl, input bit pu, input bit po,
    input logic [VLEN-1:0] d, input bit sv, input int sid,
    input bit rr, input int rid);
    rst_i        = rs;
    flush_i      = fl;
    push_i       = pu;
    pop_i        = po;
    data_i       = d;
    ckpt_save_i  = sv;
    ckpt_id_i    = 2'(sid);
    restore_i    = rr;
    restore_id_i = 2'(rid);
    model_step(rs, fl, pu, po, d, sv, sid, rr, rid);
    @(posedge clk);
    #1;
    rst_i       = 0;
    flush_i     = 0;
    push_i      = 0;
    pop_i       = 0;
    ckpt_save_i = 0;
    restore_i   = 0;
  endtask

  task automatic do_rst();
    step(1, 0, 0, 0, '0, 0, 0, 0, 0);
  endtask
  task automatic do_push(input logic [VLEN-1:0] d);
    step(0, 0, 1, 0, d, 0, 0, 0, 0);
  endtask
  task automatic do_pop();
    step(0, 0, 0, 1, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_rst();
    n_run++;
    if (valid_o !== 1'b0 || data_o !== '0 ||
        occupancy_o !== 3'd0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: v=%0b d=%h occ=%0d ovf=%0b want 0/0/0/0",
               valid_o, data_o, occupancy_o, overflow_o);
    end
  endtask

  task automatic test_push_pop();
    logic [VLEN-1:0] exp_d [3];
    exp_d[0] = 64'h200;
    exp_d[1] = 64'h100;
    exp_d[2] = 64'h0;
    do_rst();
    do_push(64'h100);
    do_push(64'h200);
    do_push(64'h300);
    n_run++;
    if (data_o !== 64'h300 || occupancy_o !== 3'd3) begin
      n_fail++;
      $display("FAIL push3: d=%h occ=%0d want 300/3", data_o, occupancy_o);
    end
    for (int i = 0; i < 3; i++) begin
      do_pop();
      n_run++;
      if (data_o !== exp_d[i] || valid_o !== (i < 2)) begin
        n_fail++;
        $display("FAIL pop%0d: d=%h v=%0b want %h", i, data_o, valid_o,
                 exp_d[i]);
      end
    end
    do_pop();
    n_run++;
    if (occupancy_o !== 3'd0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow: occ=%0d want 0", occupancy_o);
    end
  endtask

  task automatic test_overflow();
    do_rst();
    for (int i = 1; i <= 5; i++) begin
      do_push(VLEN'(i));
      n_run++;
      if (overflow_o !== (i == 5)) begin
        n_fail++;
        $display("FAIL ovf_push%0d: ovf=%0b want %0b", i, overflow_o, i == 5);
      end
    end
    n_run++;
    if (occupancy_o !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_occ: occ=%0d want 4", occupancy_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (data_o !== VLEN'(5 - i) || (i > 0 && overflow_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: d=%h ovf=%0b want %0d", i, data_o,
                 overflow_o, 5 - i);
      end
      do_pop();
    end
    n_run++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_lost: v=%0b want 0", valid_o);
    end
  endtask

  task automatic test_push_pop_combo();
    do_rst();
    do_push(64'hA);
    do_push(64'hB);
    step(0, 0, 1, 1, 64'hC, 0, 0, 0, 0);
    n_run++;
    if (data_o !== 64'hC || occupancy_o !== 3'd2) begin
      n_fail++;
      $display("FAIL pushpop: d=%h occ=%0d want C/2", data_o, occupancy_o);
    end
    do_pop();
    n_run++;
    if (data_o !== 64'hA) begin
      n_fail++;
      $display("FAIL pushpop_pop: d=%h want A", data_o);
    end
    do_rst();
    step(0, 0, 1, 1, 64'hE, 0, 0, 0, 0);
    n_run++;
    if (data_o !== 64'hE || occupancy_o !== 3'd1) begin
      n_fail++;
      $display("FAIL pushpop_empty: d=%h occ=%0d want E/1", data_o,
               occupancy_o);
    end
  endtask

  task automatic test_ckpt_repair();
    do_rst();
    do_push(64'hA);
    do_push(64'hB);
    step(0, 0, 0, 0, '0, 1, 2, 0, 0);
    do_pop();
    do_push(64'hD);
    n_run++;
    if (data_o !== 64'hD) begin
      n_fail++;
      $display("FAIL spec_push: d=%h want D", data_o);
    end
    step(0, 0, 0, 0, '0, 0, 0, 1, 2);
    n_run++;
    if (data_o !== 64'hB || occupancy_o !== 3'd2) begin
      n_fail++;
      $display("FAIL repair: d=%h occ=%0d want B/2", data_o, occupancy_o);
    end
    do_pop();
    n_run++;
    if (data_o !== 64'hA) begin
      n_fail++;
      $display("FAIL repair_pop: d=%h want A", data_o);
    end
  endtask

  task automatic test_invalid_restore_flush();
    do_rst();
    do_push(64'h55);
    step(0, 0, 1, 0, 64'h66, 0, 0, 1, 1);
    n_run++;
    if (data_o !== 64'h55 || occupancy_o !== 3'd1) begin
      n_fail++;
      $display("FAIL inv_restore: d=%h occ=%0d want 55/1", data_o,
               occupancy_o);
    end
    step(0, 0, 0, 0, '0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 64'h77, 0, 0, 0, 0);
    n_run++;
    if (valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
      n_fail++;
      $display("FAIL flush: v=%0b occ=%0d want 0/0", valid_o, occupancy_o);
    end
    step(0, 0, 0, 0, '0, 0, 0, 1, 0);
    n_run++;
    if (valid_o !== 1'b0 || data_o !== '0) begin
      n_fail++;
      $display("FAIL flush_restore: v=%0b d=%h want 0/0", valid_o, data_o);
    end
  endtask

  task automatic test_priority();
    do_rst();
    do_push(64'h11);
    step(0, 0, 0, 0, '0, 1, 3, 0, 0);
    do_push(64'h22);
    do_push(64'h33);
    step(0, 0, 1, 0, 64'h44, 1, 3, 1, 3);
    n_run++;
    if (data_o !== 64'h11 || occupancy_o !== 3'd1) begin
      n_fail++;
      $display("FAIL prio_restore: d=%h occ=%0d want 11/1", data_o,
               occupancy_o);
    end
    step(0, 0, 0, 0, '0, 0, 0, 1, 3);
    n_run++;
    if (data_o !== 64'h33 || occupancy_o !== 3'd3) begin
      n_fail++;
      $display("FAIL prio_resave: d=%h occ=%0d want 33/3", data_o,
               occupancy_o);
    end
    do_push(64'h77);
    do_push(64'h88);
    step(1, 0, 1, 0, 64'h99, 1, 0, 0, 0);
    n_run++;
    if (valid_o !== 1'b0 || data_o !== '0 ||
        occupancy_o !== 3'd0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%0b d=%h occ=%0d ovf=%0b want 0",
               valid_o, data_o, occupancy_o, overflow_o);
    end
    step(0, 0, 0, 0, '0, 0, 0, 1, 3);
    n_run++;
    if (occupancy_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_inval: occ=%0d want 0", occupancy_o);
    end
  endtask

  task automatic test_random();
    logic [VLEN-1:0] exp_d;
    do_rst();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(63) == 0, $urandom_range(31) == 0,
           $urandom_range(1) == 1, $urandom_range(2) == 0,
           {$urandom, $urandom},
           $urandom_range(3) == 0, $urandom_range(NCK - 1),
           $urandom_range(7) == 0, $urandom_range(NCK - 1));
      exp_d = (m_cnt > 0) ? m_mem[m_tos] : '0;
      n_run++;
      if (data_o !== exp_d || valid_o !== (m_cnt > 0) ||
          occupancy_o !== 3'(m_cnt) || overflow_o !== m_ovf) begin
        n_fail++;
        $display("FAIL rand%0d: d=%h v=%0b occ=%0d ovf=%0b want %h/%0d/%0b",
                 c, data_o, valid_o, occupancy_o, overflow_o,
                 exp_d, m_cnt, m_ovf);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_tos = 0;
    m_cnt = 0;
    m_ovf = 0;
    for (int i = 0; i < NCK; i++) begin
      ck_v[i]   = 0;
      ck_tos[i] = 0;
      ck_cnt[i] = 0;
      ck_top[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_push_pop_combo();
    test_ckpt_repair();
    test_invalid_restore_flush();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
